// File: rtl/aes_pkg.sv
// Shared AES constants, column index type, controller FSM encoding and
// column extract/insert helpers.
package aes_pkg;

  localparam int unsigned AES_STATE_W  = 128;
  localparam int unsigned AES_COL_W    = 32;
  localparam int unsigned AES_NUM_COLS = 4;

  typedef logic [1:0] col_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

  // Column 0 is the most significant word of the state.
  function automatic logic [AES_COL_W-1:0] col_get(input logic [AES_STATE_W-1:0] s,
                                                  input col_idx_t c);
    logic [AES_COL_W-1:0] r;
    r = s[127:96];
    unique case (c)
      2'd0: r = s[127:96];
      2'd1: r = s[95:64];
      2'd2: r = s[63:32];
      2'd3: r = s[31:0];
      default: r = s[127:96];
    endcase
    return r;
  endfunction

  function automatic logic [AES_STATE_W-1:0] col_set(input logic [AES_STATE_W-1:0] s,
                                                    input col_idx_t c,
                                                    input logic [AES_COL_W-1:0] v);
    logic [AES_STATE_W-1:0] r;
    r = s;
    unique case (c)
      2'd0: r[127:96] = v;
      2'd1: r[95:64]  = v;
      2'd2: r[63:32]  = v;
      2'd3: r[31:0]   = v;
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_mixcolumn_ctrl_if.sv
// Input and output valid/ready channels of the InvMixColumns sequencer.
interface aes_inv_mixcolumn_ctrl_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] in_state;
  logic                   in_bypass;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] out_state;

  modport master (
    output in_valid, in_state, in_bypass, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_bypass, out_ready,
    output in_ready, out_valid, out_state
  );

endinterface

// File: rtl/aes_inv_mixcolumn.sv
// Combinational InvMixColumns on one 32-bit column (byte 0 = MSB).
module aes_inv_mixcolumn
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] inv_mixcolumn_in,
  output logic [AES_COL_W-1:0] inv_mixcolumn_out
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by the fixed InvMixColumns coefficients 9, 11, 13, 14.
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8, r;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    r  = 8'h00;
    unique case (k)
      4'd9:    r = x8 ^ b;
      4'd11:   r = x8 ^ x2 ^ b;
      4'd13:   r = x8 ^ x4 ^ b;
      4'd14:   r = x8 ^ x4 ^ x2;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [7:0] a0, a1, a2, a3;

  assign a0 = inv_mixcolumn_in[31:24];
  assign a1 = inv_mixcolumn_in[23:16];
  assign a2 = inv_mixcolumn_in[15:8];
  assign a3 = inv_mixcolumn_in[7:0];

  assign inv_mixcolumn_out[31:24] = gm(a0, 4'd14) ^ gm(a1, 4'd11) ^ gm(a2, 4'd13) ^ gm(a3, 4'd9);
  assign inv_mixcolumn_out[23:16] = gm(a0, 4'd9)  ^ gm(a1, 4'd14) ^ gm(a2, 4'd11) ^ gm(a3, 4'd13);
  assign inv_mixcolumn_out[15:8]  = gm(a0, 4'd13) ^ gm(a1, 4'd9)  ^ gm(a2, 4'd14) ^ gm(a3, 4'd11);
  assign inv_mixcolumn_out[7:0]   = gm(a0, 4'd11) ^ gm(a1, 4'd13) ^ gm(a2, 4'd9)  ^ gm(a3, 4'd14);

endmodule

// File: rtl/aes_inv_mixcolumn_ctrl.sv
// Column-serial InvMixColumns sequencer: accept a state, transform one column
// per clock through a single shared datapath, then present the result.
module aes_inv_mixcolumn_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  aes_inv_mixcolumn_ctrl_if.slave   bus,
  output logic                      busy,
  output logic [CNT_W-1:0]          blk_cnt
);

  fsm_state_t             state, state_nxt;
  logic                   in_ready_nxt, out_valid_nxt, busy_nxt;
  logic                   accept, release_blk;
  logic [AES_STATE_W-1:0] st_reg;
  logic                   byp_reg;
  col_idx_t               col;
  logic [AES_COL_W-1:0]   col_cur, col_mix, col_wr;

  // State register; handshake flags are registered copies decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.in_ready  <= in_ready_nxt;
      bus.out_valid <= out_valid_nxt;
      busy          <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.in_valid)  state_nxt = ST_BUSY;
      ST_BUSY: if (col == 2'd3)   state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    busy_nxt      = 1'b0;
    accept        = 1'b0;
    release_blk   = 1'b0;
    in_ready_nxt  = (state_nxt == ST_IDLE);
    out_valid_nxt = (state_nxt == ST_DONE);
    busy_nxt      = (state_nxt == ST_BUSY) || (state_nxt == ST_DONE);
    accept        = (state == ST_IDLE) && bus.in_valid;
    release_blk   = (state == ST_DONE) && bus.out_ready;
  end

  assign col_cur = col_get(st_reg, col);
  assign col_wr  = byp_reg ? col_cur : col_mix;

  aes_inv_mixcolumn u_mix (
    .inv_mixcolumn_in  (col_cur),
    .inv_mixcolumn_out (col_mix)
  );

  // Capture, per-column write-back and completed-block count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_reg  <= '0;
      byp_reg <= 1'b0;
      col     <= '0;
      blk_cnt <= '0;
    end else begin
      if (accept) begin
        st_reg  <= bus.in_state;
        byp_reg <= bus.in_bypass;
        col     <= '0;
      end else if (state == ST_BUSY) begin
        st_reg <= col_set(st_reg, col, col_wr);
        col    <= col_idx_t'(col + 2'd1);
      end
      if (release_blk) blk_cnt <= blk_cnt + CNT_W'(1);
    end
  end

  assign bus.out_state = st_reg;

endmodule

// File: tb/tb_aes_inv_mixcolumn_ctrl.sv
// Directed scoreboard bench for the InvMixColumns sequencer (CNT_W = 3).
module tb_aes_inv_mixcolumn_ctrl;
  import aes_pkg::*;

  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             busy;
  logic [CNT_W-1:0] blk_cnt;

  always #5 clk = ~clk;

  aes_inv_mixcolumn_ctrl_if bus();

  aes_inv_mixcolumn_ctrl #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .blk_cnt (blk_cnt)
  );

  int               checks = 0;
  int               errors = 0;
  longint           cyc    = 0;
  logic [127:0]     exp_q[$];
  logic [CNT_W-1:0] exp_blk = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offer one block, push its expected result, drop in_valid after the accept edge.
  task automatic send(input logic [127:0] s, input logic b, input logic [127:0] e);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready", 128'(bus.in_ready), 128'(1));
    bus.in_valid  = 1'b1;
    bus.in_state  = s;
    bus.in_bypass = b;
    exp_q.push_back(e);
    tick();
    bus.in_valid  = 1'b0;
    bus.in_state  = rnd128();
    bus.in_bypass = ~b;
  endtask

  // Wait for out_valid, check latency and data, then complete the handshake.
  task automatic recv(input string tag, input int exp_lat, output longint t_out);
    int           lat;
    logic [127:0] e;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    t_out = cyc;
    chk({tag, "_sb"}, 128'(exp_q.size() != 0), 128'(1));
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk({tag, "_data"}, bus.out_state, e);
    bus.out_ready = 1'b1;
    tick();
    exp_blk++;
    chk({tag, "_blk_cnt"}, 128'(blk_cnt), 128'(exp_blk));
    chk({tag, "_ready_after"}, 128'(bus.in_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] blk_a, blk_a_inv, d;
    longint       t0, t1;

    blk_a     = 128'h8e4da1bc_4d7ebdf8_9fdc589d_01010101;
    blk_a_inv = 128'hdb135345_2d26314c_f20a225c_01010101;

    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_busy",      128'(busy),          128'(0));
    chk("rst_blk_cnt",   128'(blk_cnt),       128'(0));
    chk("rst_out_state", bus.out_state,       128'(0));
    tick();
    tick();
    rst_n = 1'b1;

    // Known-answer block, transform enabled.
    bus.out_ready = 1'b1;
    send(blk_a, 1'b0, blk_a_inv);
    chk("a_busy",     128'(busy),         128'(1));
    chk("a_in_ready", 128'(bus.in_ready), 128'(0));
    recv("kat", 4, t0);

    // Same block bypassed.
    send(blk_a, 1'b1, blk_a);
    recv("bypass", 4, t0);

    // Stalled output: held stable, second in_valid ignored.
    bus.out_ready = 1'b0;
    send('0, 1'b0, '0);
    for (int i = 0; i < 4; i++) tick();
    chk("stall_valid_lat", 128'(bus.out_valid), 128'(1));
    bus.in_valid = 1'b1;
    bus.in_state = rnd128();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_out_valid", 128'(bus.out_valid), 128'(1));
      chk("stall_out_state", bus.out_state,       128'(0));
      chk("stall_in_ready",  128'(bus.in_ready),  128'(0));
    end
    bus.in_valid = 1'b0;
    recv("stall", 0, t0);
    chk("stall_busy_after", 128'(busy), 128'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stall_no_capture", 128'(bus.out_valid), 128'(0));
    end

    // Back-to-back with in_valid held high.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_bypass = 1'b0;
    bus.in_state  = {4{32'h8e4da1bc}};
    exp_q.push_back({4{32'hdb135345}});
    tick();
    chk("b2b_busy", 128'(busy), 128'(1));
    bus.in_state = {4{32'h01010101}};
    exp_q.push_back({4{32'h01010101}});
    recv("b2b0", 4, t0);
    tick();
    bus.in_valid = 1'b0;
    recv("b2b1", 4, t1);
    chk("b2b_spacing", 128'(t1 - t0), 128'(6));

    // Reset while busy at column 2; the block must vanish.
    bus.in_valid = 1'b1;
    bus.in_state = {4{32'h9fdc589d}};
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  128'(bus.in_ready),  128'(1));
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_busy",      128'(busy),          128'(0));
    chk("mid_rst_out_state", bus.out_state,       128'(0));
    chk("mid_rst_blk_cnt",   128'(blk_cnt),       128'(0));
    exp_blk = '0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    send({4{32'h4d7ebdf8}}, 1'b0, {4{32'h2d26314c}});
    recv("post_rst", 4, t0);

    // Counter wrap: nine more bypassed blocks take blk_cnt 1 -> ... 7 -> 0 -> 1 -> 2.
    for (int i = 0; i < 9; i++) begin
      d = rnd128();
      send(d, 1'b1, d);
      recv("wrap", 4, t0);
    end
    chk("wrap_final_cnt", 128'(blk_cnt), 128'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
